// File: rtl/sharpen_pkg.sv
// Shared types and helpers for the 3x3 sharpening pipeline.
package sharpen_pkg;

    localparam int PIX_W = 8;
    localparam int KW    = 3;
    localparam int WIN_W = PIX_W * KW * KW;

    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [WIN_W-1:0] win_t;

    // Byte slot of window element at row r (0 = top/oldest), column c (0 = left).
    function automatic int win_idx(input int r, input int c);
        return KW * r + c;
    endfunction

endpackage

// File: rtl/sharpen_linebuf.sv
// Two row memories sharing one address: lb_top holds row-2, lb_mid holds row-1.
// Reads are combinational so the column for the current pixel is available
// in the same cycle it is accepted; contents are never reset.
module sharpen_linebuf
    import sharpen_pkg::*;
#(
    parameter int WIDTH = 768,
    parameter int XW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [XW-1:0] addr,
    input  pix_t          wdata,
    output pix_t          top_rd,
    output pix_t          mid_rd
);

    pix_t lb_top_q [WIDTH];
    pix_t lb_mid_q [WIDTH];
    pix_t lb_top_d;
    pix_t lb_mid_d;

    assign top_rd = lb_top_q[addr];
    assign mid_rd = lb_mid_q[addr];

    // On write the middle row ages into the top row and the new pixel becomes the middle row.
    always_comb begin
        lb_top_d = lb_mid_q[addr];
        lb_mid_d = wdata;
    end

    // Row storage update on each accepted pixel.
    always_ff @(posedge clk) begin
        if (we) begin
            lb_top_q[addr] <= lb_top_d;
            lb_mid_q[addr] <= lb_mid_d;
        end
    end

endmodule

// File: rtl/sharpen_window_gen.sv
// Raster pixel stream -> 3x3 neighbourhoods for every interior pixel.
// One output register; ready propagates combinationally from downstream.
module sharpen_window_gen
    import sharpen_pkg::*;
#(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512,
    parameter int XW     = $clog2(WIDTH),
    parameter int YW     = $clog2(HEIGHT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    pix_in,
    input  logic          pix_sof,
    input  logic          pix_valid,
    output logic          pix_ready,
    output logic [71:0]   win_out,
    output logic [XW-1:0] win_x,
    output logic [YW-1:0] win_y,
    output logic          win_last,
    output logic          win_valid,
    input  logic          win_ready,
    output logic          frame_err
);

    // Two most recent columns; [0] = left, [1] = middle; inner index 0 = top row.
    logic [1:0][KW-1:0][PIX_W-1:0] sw_q, sw_d;
    logic [KW-1:0][PIX_W-1:0]      new_col;

    logic [XW-1:0] col_q, col_d;
    logic [YW-1:0] row_q, row_d;
    win_t          win_q, win_d;
    logic [XW-1:0] win_x_q, win_x_d;
    logic [YW-1:0] win_y_q, win_y_d;
    logic          win_last_q, win_last_d;
    logic          win_valid_q, win_valid_d;
    logic          frame_err_q, frame_err_d;

    logic          accept;
    logic          at_origin;
    logic          sof_restart;
    logic          emit;
    logic [XW-1:0] ecol;
    logic [YW-1:0] erow;
    pix_t          lb_top_rd;
    pix_t          lb_mid_rd;

    // Handshake and effective position: a misplaced SOF restarts the frame at (0,0).
    always_comb begin
        pix_ready   = !win_valid_q || win_ready;
        accept      = pix_valid && pix_ready;
        at_origin   = (col_q == '0) && (row_q == '0);
        sof_restart = pix_sof && !at_origin;
        ecol        = sof_restart ? '0 : col_q;
        erow        = sof_restart ? '0 : row_q;
        new_col[0]  = lb_top_rd;
        new_col[1]  = lb_mid_rd;
        new_col[2]  = pix_in;
        emit        = accept && (erow >= YW'(2)) && (ecol >= XW'(2));
    end

    sharpen_linebuf #(
        .WIDTH (WIDTH),
        .XW    (XW)
    ) u_linebuf (
        .clk    (clk),
        .we     (accept),
        .addr   (ecol),
        .wdata  (pix_in),
        .top_rd (lb_top_rd),
        .mid_rd (lb_mid_rd)
    );

    // Next-state: raster counters, column shift, window load and valid/err tracking.
    always_comb begin
        sw_d        = sw_q;
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        win_x_d     = win_x_q;
        win_y_d     = win_y_q;
        win_last_d  = win_last_q;
        win_valid_d = win_valid_q;
        frame_err_d = accept && (sof_restart || (!pix_sof && at_origin));

        if (win_ready) begin
            win_valid_d = 1'b0;
        end

        if (accept) begin
            sw_d[0] = sw_q[1];
            sw_d[1] = new_col;
            if (ecol == XW'(WIDTH - 1)) begin
                col_d = '0;
                row_d = (erow == YW'(HEIGHT - 1)) ? '0 : erow + YW'(1);
            end else begin
                col_d = ecol + XW'(1);
                row_d = erow;
            end
        end

        if (emit) begin
            for (int r = 0; r < KW; r++) begin
                win_d[PIX_W*win_idx(r, 0) +: PIX_W] = sw_q[0][r];
                win_d[PIX_W*win_idx(r, 1) +: PIX_W] = sw_q[1][r];
                win_d[PIX_W*win_idx(r, 2) +: PIX_W] = new_col[r];
            end
            win_x_d     = ecol - XW'(1);
            win_y_d     = erow - YW'(1);
            win_last_d  = (ecol == XW'(WIDTH - 1)) && (erow == YW'(HEIGHT - 1));
            win_valid_d = 1'b1;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            win_x_q     <= '0;
            win_y_q     <= '0;
            win_last_q  <= 1'b0;
            win_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            win_x_q     <= win_x_d;
            win_y_q     <= win_y_d;
            win_last_q  <= win_last_d;
            win_valid_q <= win_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Column shift register; always refilled before it contributes to a window.
    always_ff @(posedge clk) begin
        sw_q <= sw_d;
    end

    assign win_out   = win_q;
    assign win_x     = win_x_q;
    assign win_y     = win_y_q;
    assign win_last  = win_last_q;
    assign win_valid = win_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sharpen_window_gen.sv
// Bench for sharpen_window_gen on a 5x4 frame with an image-array reference model.
module tb_sharpen_window_gen;

    localparam int W = 5;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pix_in;
    logic        pix_sof;
    logic        pix_valid;
    logic        pix_ready;
    logic [71:0] win_out;
    logic [2:0]  win_x;
    logic [1:0]  win_y;
    logic        win_last;
    logic        win_valid;
    logic        win_ready;
    logic        frame_err;

    sharpen_window_gen #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_in    (pix_in),
        .pix_sof   (pix_sof),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .win_out   (win_out),
        .win_x     (win_x),
        .win_y     (win_y),
        .win_last  (win_last),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] win;
        int          x;
        int          y;
        bit          last;
    } wrec_t;

    int    vecs = 0;
    int    errs = 0;
    wrec_t exp_q[$];
    wrec_t log_q[$];
    int    err_pulses = 0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the frame as a plain image, windows cut from it by position.
    logic [7:0]  img [H][W];
    int          mcol = 0;
    int          mrow = 0;
    bit          err_pend = 0;
    bit          held = 0;
    logic [71:0] h_win;
    logic [2:0]  h_x;
    logic [1:0]  h_y;
    logic        h_last;

    always @(negedge clk) begin
        if (reset) begin
            mcol = 0; mrow = 0; err_pend = 0; held = 0;
            exp_q.delete();
        end else begin
            chk("frame_err", frame_err, err_pend);
            chk("pix_ready", pix_ready, !win_valid || win_ready);
            if (held) begin
                chk("hold_win", win_out, h_win);
                chk("hold_x", win_x, h_x);
                chk("hold_y", win_y, h_y);
                chk("hold_last", win_last, h_last);
                chk("hold_valid", win_valid, 1'b1);
            end
            if (win_valid && win_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_window", 1'b1, 1'b0);
                end else begin
                    wrec_t e;
                    e = exp_q.pop_front();
                    chk("win_out", win_out, e.win);
                    chk("win_x", win_x, e.x);
                    chk("win_y", win_y, e.y);
                    chk("win_last", win_last, e.last);
                end
                log_q.push_back('{win_out, int'(win_x), int'(win_y), win_last});
            end
            held = win_valid && !win_ready;
            h_win = win_out; h_x = win_x; h_y = win_y; h_last = win_last;
            if (frame_err) err_pulses++;

            err_pend = 0;
            if (pix_valid && pix_ready) begin
                bit at0;
                at0 = (mcol == 0) && (mrow == 0);
                err_pend = (pix_sof && !at0) || (!pix_sof && at0);
                if (pix_sof) begin mcol = 0; mrow = 0; end
                img[mrow][mcol] = pix_in;
                if (mrow >= 2 && mcol >= 2) begin
                    wrec_t e;
                    for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++)
                            e.win[8*(3*r+c) +: 8] = img[mrow-2+r][mcol-2+c];
                    e.x = mcol - 1;
                    e.y = mrow - 1;
                    e.last = (mcol == W-1) && (mrow == H-1);
                    exp_q.push_back(e);
                end
                mcol++;
                if (mcol == W) begin
                    mcol = 0;
                    mrow = (mrow == H-1) ? 0 : mrow + 1;
                end
            end
        end
    end

    // Drive one pixel and wait (bounded) until it is taken.
    task automatic send_pix(input logic [7:0] p, input logic sof);
        bit acc;
        acc = 0;
        pix_in = p; pix_sof = sof; pix_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = pix_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("pix_accept_timeout", 1'b0, 1'b1);
        pix_valid = 1'b0; pix_sof = 1'b0;
    endtask

    task automatic send_frame(input int base, input logic sof);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send_pix(8'(base + 10*r + c), sof && r == 0 && c == 0);
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    localparam logic [71:0] F0_FIRST = 72'h161514_0C0B0A_020100;
    localparam logic [71:0] F0_LAST  = 72'h222120_181716_0E0D0C;
    localparam logic [71:0] F1_FIRST = 72'h7A7978_706F6E_666564;

    initial begin
        int  b;
        int  e0;
        bit  found;
        reset = 1'b1; pix_in = '0; pix_sof = 1'b0; pix_valid = 1'b0; win_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", win_valid, 1'b0);
        chk("rst_ready", pix_ready, 1'b1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Normal frame, continuous stream.
        b = log_q.size(); e0 = err_pulses;
        send_frame(0, 1'b1);
        drain();
        chk("t1_count", log_q.size() - b, 6);
        chk("t1_errs", err_pulses - e0, 0);
        if (log_q.size() >= b + 6) begin
            chk("t1_first_win", log_q[b].win, F0_FIRST);
            chk("t1_first_x", log_q[b].x, 1);
            chk("t1_first_y", log_q[b].y, 1);
            chk("t1_first_last", log_q[b].last, 1'b0);
            chk("t1_last_win", log_q[b+5].win, F0_LAST);
            chk("t1_last_centre", log_q[b+5].win[39:32], 23);
            chk("t1_last_x", log_q[b+5].x, 3);
            chk("t1_last_y", log_q[b+5].y, 2);
            chk("t1_last_flag", log_q[b+5].last, 1'b1);
        end

        // Stall downstream for 3 cycles while window 2 is presented.
        b = log_q.size(); found = 0;
        fork
            send_frame(0, 1'b1);
            begin
                for (int i = 0; i < 200 && !found; i++) begin
                    @(posedge clk);
                    #1;
                    if (win_valid && log_q.size() == b + 1) found = 1;
                end
                if (found) begin
                    win_ready = 1'b0;
                    repeat (3) begin
                        @(negedge clk);
                        chk("t2_stall_ready", pix_ready, 1'b0);
                    end
                    @(posedge clk);
                    #1;
                    win_ready = 1'b1;
                end
            end
        join
        chk("t2_stall_seen", found, 1'b1);
        drain();
        chk("t2_count", log_q.size() - b, 6);
        if (log_q.size() >= b + 6) begin
            chk("t2_second_win", log_q[b+1].win, 72'h171615_0D0C0B_030201);
            chk("t2_last_win", log_q[b+5].win, F0_LAST);
        end

        // Reset mid-frame after 7 pixels.
        for (int i = 0; i < 7; i++) send_pix(8'(10*(i/W) + i%W), i == 0);
        reset = 1'b1;
        #1;
        chk("t3_rst_win", win_out, 72'h0);
        chk("t3_rst_x", win_x, 3'd0);
        chk("t3_rst_y", win_y, 2'd0);
        chk("t3_rst_last", win_last, 1'b0);
        chk("t3_rst_valid", win_valid, 1'b0);
        chk("t3_rst_err", frame_err, 1'b0);
        chk("t3_rst_ready", pix_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        b = log_q.size(); e0 = err_pulses;
        send_frame(0, 1'b1);
        drain();
        chk("t3_count", log_q.size() - b, 6);
        chk("t3_errs", err_pulses - e0, 0);
        if (log_q.size() >= b + 1) chk("t3_first_win", log_q[b].win, F0_FIRST);

        // SOF at row 1 / col 3 restarts the frame.
        b = log_q.size(); e0 = err_pulses;
        for (int i = 0; i < 8; i++) send_pix(8'(10*(i/W) + i%W), i == 0);
        send_frame(100, 1'b1);
        drain();
        chk("t4_errs", err_pulses - e0, 1);
        chk("t4_count", log_q.size() - b, 6);
        if (log_q.size() >= b + 1) begin
            chk("t4_first_win", log_q[b].win, F1_FIRST);
            chk("t4_first_x", log_q[b].x, 1);
            chk("t4_first_y", log_q[b].y, 1);
        end

        // Two frames back to back.
        b = log_q.size(); e0 = err_pulses;
        send_frame(0, 1'b1);
        send_frame(100, 1'b1);
        drain();
        chk("t5_count", log_q.size() - b, 12);
        chk("t5_errs", err_pulses - e0, 0);
        if (log_q.size() >= b + 12) begin
            chk("t5_f0_last", log_q[b+5].last, 1'b1);
            chk("t5_f1_first", log_q[b+6].win, F1_FIRST);
            chk("t5_f1_centre", log_q[b+6].win[39:32], 111);
            chk("t5_f1_x", log_q[b+6].x, 1);
            chk("t5_f1_y", log_q[b+6].y, 1);
            chk("t5_f1_last", log_q[b+11].last, 1'b1);
        end

        // Frame start without SOF.
        b = log_q.size(); e0 = err_pulses;
        send_frame(0, 1'b0);
        drain();
        chk("t6_errs", err_pulses - e0, 1);
        chk("t6_count", log_q.size() - b, 6);
        if (log_q.size() >= b + 6) begin
            chk("t6_first_win", log_q[b].win, F0_FIRST);
            chk("t6_last_win", log_q[b+5].win, F0_LAST);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/sharpen_window_gen.md
Name: sharpen_window_gen

Overview:
Upstream stage of the 3x3 sharpening filter. It accepts a raster-order 8-bit grayscale pixel stream with start-of-frame marking. It keeps two previous image rows in line buffers and emits one complete 3x3 neighbourhood per interior pixel, with no padding, plus centre coordinates and an end-of-frame marker. Both sides use a valid/ready handshake, so the downstream convolution can stall the stream without losing pixels.

Parameters:
WIDTH, 768, pixels per row (>=3)
HEIGHT, 512, rows per frame (>=3)
XW, $clog2(WIDTH), column/coordinate width
YW, $clog2(HEIGHT), row/coordinate width

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
pix_in  in  8  input pixel
pix_sof  in  1  marks the first pixel of a frame; qualified by pix_valid
pix_valid  in  1  pix_in/pix_sof valid
pix_ready  out  1  stage can accept a pixel this cycle
win_out  out  72  3x3 window; byte index 3*r+c, r=0 top (oldest row), c=0 left
win_x  out  XW  column of the window centre
win_y  out  YW  row of the window centre
win_last  out  1  last window of the frame
win_valid  out  1  window outputs valid
win_ready  in  1  downstream accepts the window
frame_err  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset values: win_out=0, win_x=0, win_y=0, win_last=0, win_valid=0, frame_err=0. Counters col=0, row=0. Line-buffer and shift-window contents are not reset, because they are never emitted before being refilled.
- Reset mid-frame discards all state. The next pixel is treated as (0,0).
- Handshake:
  - pix_ready = !win_valid || win_ready (single output register, combinational ready path).
  - A pixel is accepted when pix_valid && pix_ready.
  - While win_valid && !win_ready: pix_ready=0 and all outputs are held stable.
- On each accepted pixel at (col,row):
  - Window columns shift left. The new right column is {lb_top[col], lb_mid[col], pix_in}, top to bottom.
  - Line buffers update: lb_top[col] <= lb_mid[col]; lb_mid[col] <= pix_in.
  - col increments. At WIDTH-1 it wraps to 0 and row increments. At (WIDTH-1, HEIGHT-1) both wrap to 0.
- Window emission:
  - If row>=2 && col>=2, the next cycle win_valid=1, win_x=col-1, win_y=row-1, and win_last=1 iff (col,row)=(WIDTH-1,HEIGHT-1).
  - Latency is 1 cycle from accepting the completing pixel.
  - Windows never span a row boundary, because col>=2 guarantees a fresh 3-column window.
- Per frame: exactly (WIDTH-2)*(HEIGHT-2) windows.
- win_valid clears after handshake completion unless a new window is loaded in the same cycle. Back-to-back throughput is 1 window/cycle.
- Framing:
  - pix_sof at (0,0) is normal.
  - pix_sof at any other position: frame_err pulses, counters restart so this pixel is treated as (0,0), and no window is emitted until two new rows are complete. A window already in the output register is still delivered.
  - Accepted pixel at (0,0) without pix_sof: frame_err pulses, and the frame is processed normally.
- Pixels are carried unmodified; there is no arithmetic on pixel values.

Decomposition:
- Package sharpen_pkg:
  - PIX_W=8, KW=3, WIN_W=72
  - typedef pix_t (8-bit)
  - typedef win_t (72-bit packed)
  - win_idx(r,c) = 3*r+c helper, shared with the convolution stage.
- Sub-module sharpen_linebuf: two WIDTH x 8 row memories with a shared address.
  - Read of lb_top/lb_mid at col.
  - Write of both on accept.
  - Implementable as registers or RAM with matching read timing.

Test Plan:
- Reset mid-frame (asserted at pixel 7, released) -> all outputs 0, pix_ready=1. Next frame with sof produces correct windows from (1,1).
- WIDTH=5, HEIGHT=4, pixel=10*row+col, continuous valid, win_ready=1 -> 6 windows.
  - First window: win_x=1, win_y=1, bytes 0..8 = 0,1,2,10,11,12,20,21,22.
  - Last window: (3,2), centre=23, win_last=1 only on it.
- Same frame, win_ready low for 3 cycles on window 2 -> win_out held, pix_ready=0, no pixel lost, identical 6-window sequence.
- pix_sof at row1/col3 -> frame_err 1-cycle pulse. The next window is emitted only after 2 rows plus 3 pixels of the new frame, at (1,1).
- Two back-to-back frames, no gap -> 6 windows each, second frame restarts at (1,1), frame_err never asserts.
- First pixel of frame without pix_sof -> frame_err pulse, and the frame yields all 6 correct windows.
